// File: rtl/debounce_fsm.sv
// Push-button debouncer: 2-flop synchronizer feeding a four-state qualify FSM
// with an N-bit down-counter, plus registered rise/fall strobes.
module debounce_fsm #(
  parameter int N = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic db_level,
  output logic db_tick,
  output logic db_fall
);

  // Bit 1 of the encoding is the debounced level, so db_level is a bare flop output.
  localparam logic [1:0] ZERO  = 2'b00;
  localparam logic [1:0] WAIT1 = 2'b01;
  localparam logic [1:0] ONE   = 2'b10;
  localparam logic [1:0] WAIT0 = 2'b11;

  localparam logic [N-1:0] CNT_LOAD = {N{1'b1}};
  localparam logic [N-1:0] CNT_DEC  = {{(N-1){1'b0}}, 1'b1};

  logic         r_sync_p0;
  logic         r_sync_p1;
  logic [1:0]   r_state;
  logic [N-1:0] r_cnt;
  logic         r_tick;
  logic         r_fall;

  logic [1:0]   w_state_nxt;
  logic [N-1:0] w_cnt_nxt;
  logic         w_tick_nxt;
  logic         w_fall_nxt;
  logic         w_cnt_zero;
  logic         w_s;

  // Stage p0/p1: metastability synchronizer for the asynchronous button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= btn;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_s        = r_sync_p1;
  assign w_cnt_zero = (r_cnt == '0);

  // Strobes are decided here so they land on the same edge the state enters ONE/ZERO.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tick_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      ZERO: begin
        if (w_s) begin
          w_state_nxt = WAIT1;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT1: begin
        if (!w_s) begin
          w_state_nxt = ZERO;
        end else if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CNT_DEC;
        end else begin
          w_state_nxt = ONE;
          w_tick_nxt  = 1'b1;
        end
      end
      ONE: begin
        if (!w_s) begin
          w_state_nxt = WAIT0;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT0: begin
        if (w_s) begin
          w_state_nxt = ONE;
        end else if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CNT_DEC;
        end else begin
          w_state_nxt = ZERO;
          w_fall_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ZERO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ZERO;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tick  <= w_tick_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign db_level = r_state[1];
  assign db_tick  = r_tick;
  assign db_fall  = r_fall;

endmodule
